// File: rtl/seq_shifter_pkg.sv
// Shared encodings for the sequential shifter: shift modes and FSM states.
package seq_shifter_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

endpackage

// File: rtl/shifter_step.sv
// Combinational single-bit shift step: one position of X, with the bit leaving X entering Y.
module shifter_step
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_fill,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  output logic             o_out
);

  always_comb begin
    o_x   = i_x;
    o_y   = i_y;
    o_out = 1'b0;
    unique case (i_mode)
      SH_LSL: begin
        o_out = i_x[WIDTH-1];
        o_x   = {i_x[WIDTH-2:0], i_fill};
        o_y   = {i_y[WIDTH-2:0], i_x[WIDTH-1]};
      end
      SH_LSR, SH_ASR: begin
        o_out = i_x[0];
        o_x   = {i_fill, i_x[WIDTH-1:1]};
        o_y   = {i_x[0], i_y[WIDTH-1:1]};
      end
      SH_ROL: begin
        // Rotated bit stays inside X, so Y is left untouched.
        o_out = i_x[WIDTH-1];
        o_x   = {i_x[WIDTH-2:0], i_x[WIDTH-1]};
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit per clock, valid/ready start, one-cycle done pulse.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   amt,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_ovf;
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_mode;
  logic             r_fill;

  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic             w_out;

  shifter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_x   (r_x),
    .i_y   (r_y),
    .i_fill(r_fill),
    .i_mode(r_mode),
    .o_x   (w_x_nxt),
    .o_y   (w_y_nxt),
    .o_out (w_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= SH_LSL;
      r_fill  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_x     <= A;
            r_y     <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= amt;
            r_mode  <= mode;
            // Arithmetic right replicates the sign bit captured at accept.
            r_fill  <= (mode == SH_ASR) ? A[WIDTH-1] : fill;
            r_state <= (amt != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          r_x   <= w_x_nxt;
          r_y   <= w_y_nxt;
          r_ovf <= r_ovf | ((r_mode == SH_LSL) & w_out);
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == SHW'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign busy        = (r_state == S_SHIFT);
  assign done        = (r_state == S_DONE);
  assign X           = r_x;
  assign Y           = r_y;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: arithmetic reference model with per-cycle compare plus directed vectors.
module tb_seq_shifter;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic [7:0] A = 8'h00;
  logic [2:0] amt = 3'd0;
  logic [1:0] mode = 2'b00;
  logic       fill = 1'b0;
  logic       start_ready;
  logic [7:0] X;
  logic [7:0] Y;
  logic       ovf;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_shifter #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .A          (A),
    .amt        (amt),
    .mode       (mode),
    .fill       (fill),
    .X          (X),
    .Y          (Y),
    .ovf        (ovf),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-operation result as {ovf, Y, X} from plain wide shifts.
  function automatic logic [16:0] calc(input logic [7:0] a, input int n, input logic [1:0] md,
                                       input logic f);
    logic [15:0] w;
    logic [15:0] lo_w;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  ones_lo;
    logic [7:0]  ones_hi;
    logic        fb;
    lo_w    = (16'h0001 << n) - 16'h0001;
    ones_lo = lo_w[7:0];
    ones_hi = ~(8'hFF >> n);
    case (md)
      2'b00: begin
        w = {8'h00, a} << n;
        x = w[7:0] | (f ? ones_lo : 8'h00);
        y = w[15:8];
      end
      2'b01, 2'b10: begin
        fb = (md == 2'b10) ? a[7] : f;
        w  = {a, 8'h00} >> n;
        x  = w[15:8] | (fb ? ones_hi : 8'h00);
        y  = w[7:0];
      end
      default: begin
        w = {a, a} << n;
        x = w[15:8];
        y = 8'h00;
      end
    endcase
    return {(md == 2'b00) && (y != 8'h00), y, x};
  endfunction

  // Timeline model: an accept at edge k with amount n is busy after edges k..k+n-1,
  // done after edge k+n, and ready again after edge k+n+1.
  int         cyc = 0;
  logic       m_act = 1'b0;
  int         m_acc = 0;
  int         m_n = 0;
  logic [7:0] m_x = 8'h00;
  logic [7:0] m_y = 8'h00;
  logic       m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_x   <= 8'h00;
      m_y   <= 8'h00;
      m_ovf <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if ((!m_act || cyc >= m_acc + m_n + 1) && start_valid) begin
        m_act <= 1'b1;
        m_acc <= cyc + 1;
        m_n   <= int'(amt);
        {m_ovf, m_y, m_x} <= calc(A, int'(amt), mode, fill);
      end
    end
  end

  logic e_busy;
  logic e_done;

  always @(negedge clk) begin
    e_busy = m_act && (cyc >= m_acc) && (cyc < m_acc + m_n);
    e_done = m_act && (cyc == m_acc + m_n);
    chk("cyc_busy", 32'(busy), 32'(e_busy));
    chk("cyc_done", 32'(done), 32'(e_done));
    chk("cyc_ready", 32'(start_ready), 32'(!e_busy && !e_done));
    if (!e_busy) begin
      chk("cyc_x", 32'(X), 32'(m_x));
      chk("cyc_y", 32'(Y), 32'(m_y));
      chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input int n, input logic [1:0] md, input logic f,
                        input logic [7:0] ex, input logic [7:0] ey, input logic eo,
                        input string name);
    int lat;
    @(posedge clk);
    #1;
    A = a;
    amt = 3'(n);
    mode = md;
    fill = f;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    A = ~a;
    amt = 3'(n + 3);
    fill = ~f;
    wait_done(lat);
    chk({name, "_lat"}, 32'(lat), 32'(n + 1));
    chk({name, "_x"}, 32'(X), 32'(ex));
    chk({name, "_y"}, 32'(Y), 32'(ey));
    chk({name, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    int lat;
    #12;
    chk("rst_x", 32'(X), 32'h0);
    chk("rst_y", 32'(Y), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ready", 32'(start_ready), 32'h1);

    chk("model_lsl", 32'(calc(8'hA6, 3, 2'b00, 1'b0)), 32'h1_05_30);
    chk("model_asr", 32'(calc(8'h93, 2, 2'b10, 1'b0)), 32'h0_C0_E4);
    chk("model_lsr", 32'(calc(8'h0F, 4, 2'b01, 1'b1)), 32'h0_F0_F0);
    chk("model_rol", 32'(calc(8'h81, 1, 2'b11, 1'b0)), 32'h0_00_03);

    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'b1010_0110, 3, 2'b00, 1'b0, 8'b0011_0000, 8'b0000_0101, 1'b1, "lsl");
    run_op(8'b1001_0011, 2, 2'b10, 1'b0, 8'b1110_0100, 8'b1100_0000, 1'b0, "asr");
    run_op(8'b0000_1111, 4, 2'b01, 1'b1, 8'b1111_0000, 8'b1111_0000, 1'b0, "lsr");
    run_op(8'b1000_0001, 1, 2'b11, 1'b0, 8'b0000_0011, 8'h00, 1'b0, "rol");
    run_op(8'h5A, 0, 2'b00, 1'b1, 8'h5A, 8'h00, 1'b0, "amt0_lsl");
    run_op(8'hC3, 0, 2'b10, 1'b0, 8'hC3, 8'h00, 1'b0, "amt0_asr");
    run_op(8'h80, 7, 2'b10, 1'b0, 8'hFF, 8'h00, 1'b0, "asr_max");
    run_op(8'hFF, 7, 2'b00, 1'b1, 8'hFF, 8'h7F, 1'b1, "lsl_fill1");
    run_op(8'h96, 7, 2'b11, 1'b0, 8'h4B, 8'h00, 1'b0, "rol_max");

    // start_valid held through the operation with new operands: ignored until ready again.
    @(posedge clk);
    #1;
    A = 8'hA6;
    amt = 3'd3;
    mode = 2'b00;
    fill = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    A = 8'h3F;
    amt = 3'd2;
    mode = 2'b01;
    fill = 1'b0;
    wait_done(lat);
    chk("hold_lat", 32'(lat), 32'd4);
    chk("hold_x", 32'(X), 32'h30);
    chk("hold_y", 32'(Y), 32'h05);
    chk("hold_ovf", 32'(ovf), 32'h1);
    wait_done(lat);
    start_valid = 1'b0;
    chk("b2b_lat", 32'(lat), 32'd4);
    chk("b2b_x", 32'(X), 32'h0F);
    chk("b2b_y", 32'(Y), 32'hC0);

    // Reset in the middle of a shift.
    @(posedge clk);
    #1;
    A = 8'hFF;
    amt = 3'd7;
    mode = 2'b00;
    fill = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 32'(X), 32'h0);
    chk("mid_rst_y", 32'(Y), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(start_ready), 32'h1);
    chk("mid_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done), 32'h0);
    end

    run_op(8'h3C, 5, 2'b01, 1'b1, 8'hF9, 8'hE0, 1'b0, "post_rst");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle shifter that moves a WIDTH-bit operand one bit position per clock in one of four modes, with a valid/ready start handshake and a one-cycle done pulse. It is the sequential successor to the 4-bit combinational shifter in the integer ALU. It adds configurable width, rotate and arithmetic modes, a captured shifted-out word, and a sticky overflow flag. It sits beside the adder and logic units and is started by the ALU control FSM for shift opcodes.

## Interface
- WIDTH, default 8, operand width; power of two, at least 4.
- SHW, localparam = $clog2(WIDTH), shift-amount width; legal amounts are 0..WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request to start a shift.
- start_ready  out  1  high when the block can accept a request.
- A  in  WIDTH  operand, sampled at accept.
- amt  in  SHW  shift amount, sampled at accept.
- mode  in  2  shift mode, sampled at accept:
  - 00: logical left.
  - 01: logical right.
  - 10: arithmetic right.
  - 11: rotate left.
- fill  in  1  fill bit for modes 00/01, sampled at accept; ignored in modes 10/11.
- X  out  WIDTH  shifted result.
- Y  out  WIDTH  shifted-out bits.
- ovf  out  1  overflow flag.
- busy  out  1  high while a shift is in progress.
- done  out  1  one-cycle pulse when X/Y/ovf are valid.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - Accept occurs on start_valid && start_ready at a rising edge.
  - At accept: X<=A, Y<=0, ovf<=0, count<=amt; latch mode and fill (mode 10 fill = A[WIDTH-1]).
  - Next state is SHIFT if amt!=0, else DONE.
- SHIFT: busy=1, start_ready=0. One step per cycle, decrement count; go to DONE when count reaches 1 (last step).
  - Mode 00: out=X[W-1]; X<={X[W-2:0],fill}; Y<={Y[W-2:0],out}; ovf<=ovf|out.
  - Mode 01: out=X[0]; X<={fill,X[W-1:1]}; Y<={out,Y[W-1:1]}.
  - Mode 10: same as mode 01, with fill = the latched sign bit.
  - Mode 11: X<={X[W-2:0],X[W-1]}; Y unchanged (0).
  - ovf stays 0 in modes 01/10/11.
- DONE: done=1, busy=0, start_ready=0 for exactly one cycle, then IDLE.
- X, Y and ovf hold their values after DONE until the next accept.
- start_valid while not in IDLE is ignored; there is no queuing.

## Timing
- Reset (async, rst_n=0): state=IDLE; X=0, Y=0, ovf=0, busy=0, done=0, start_ready=1.
- Reset mid-operation aborts immediately to the reset values; the in-flight result is lost.
- Latency:
  - Accept at edge k, amt=n>0: SHIFT during cycles k+1..k+n; done=1 in cycle k+n+1.
  - amt=0: done=1 in cycle k+1 with X=A, Y=0, ovf=0.
- Throughput: the next accept is possible at the edge ending the cycle after DONE, so n+2 cycles per operation.
- All outputs are registered; there are no combinational input-to-output paths except none. start_ready is decoded from state only.
- Counter width SHW; no wrap, since amt is at most WIDTH-1.

## Structure
- Package seq_shifter_pkg:
  - Mode encodings: SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROL=2'b11.
  - State enum: S_IDLE, S_SHIFT, S_DONE.
- Sub-module shifter_step: combinational single-bit step taking X, Y, fill and mode, and returning next X, next Y and out.
- Top level holds the FSM, counter and registers.

## Test plan
All cases use WIDTH=8.
- Mode 00, A=8'b1010_0110, amt=3, fill=0 -> X=8'b0011_0000, Y=8'b0000_0101, ovf=1, done 4 cycles after accept.
- Mode 10, A=8'b1001_0011, amt=2 -> X=8'b1110_0100, Y=8'b1100_0000, ovf=0.
- Mode 01, fill=1, A=8'b0000_1111, amt=4 -> X=8'b1111_0000, Y=8'b1111_0000.
- Mode 11, A=8'b1000_0001, amt=1 -> X=8'b0000_0011, Y=0, ovf=0; amt=0 on any mode -> done 1 cycle later, X=A.
- start_valid held high during SHIFT with new A -> ignored, result unaffected; back-to-back requests accepted at n+2 spacing.
- rst_n pulsed low mid-SHIFT -> X=0, Y=0, busy=0, start_ready=1 immediately, and no done pulse.
